// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Owns the Y86-64 instruction memory. A program arrives as a valid/ready byte
//   stream and is written sequentially from address 0. A combinational 10-byte
//   fetch window is served to the pipeline. cpu_run stays low until a complete,
//   error-free image is resident.
//
// Optional build macro: IMEM_CHECKSUM_EN
//   When defined, the ld_last byte is an XOR checksum of the stored bytes. It
//   is neither stored nor counted. A mismatch sends the loader to ERROR.
//
// Ports
//   clk, reset    : system clock; synchronous active-high reset
//   ld_start      : pulse that starts a new load (ignored while loading)
//   ld_valid/ld_data/ld_last/ld_ready : program byte stream
//   fetch_pc      : fetch address
//   fetch_instr   : bytes [PC..PC+9]; the byte at PC is in bits [79:72]
//   fetch_err     : the fetch window runs past MEM_BYTES
//   prog_len      : number of bytes stored by the last load
//   cpu_run       : high only in DONE (processor reset = ~cpu_run)
//   load_err      : high only in ERROR
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [63:0]       fetch_pc,
  output logic [79:0]       fetch_instr,
  output logic              fetch_err,
  output logic [ADDR_W:0]   prog_len,
  output logic              cpu_run,
  output logic              load_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam int NUM_LANES = 10;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(MEM_BYTES - 1);

  logic [1:0]      state;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] len_q;
  logic [7:0]      mem [MEM_BYTES];
  logic            xfer;
  logic            mem_we;
  logic            at_end;

  assign ld_ready = (state == S_LOAD);
  assign xfer     = ld_ready && ld_valid;
  assign at_end   = (wr_ptr == LAST_PTR);
  assign cpu_run  = (state == S_DONE);
  assign load_err = (state == S_ERR);
  assign prog_len = len_q;

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum;
  // The checksum byte itself never reaches memory.
  assign mem_we = xfer && !ld_last && !reset;
`else
  assign mem_we = xfer && !reset;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      len_q  <= '0;
`ifdef IMEM_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (xfer) begin
`ifdef IMEM_CHECKSUM_EN
            if (ld_last) begin
              state <= (csum == ld_data) ? S_DONE : S_ERR;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              len_q  <= wr_ptr + 1'b1;
              csum   <= csum ^ ld_data;
              // Last slot filled without end-of-image: stop rather than wrap.
              if (at_end) state <= S_ERR;
            end
`else
            wr_ptr <= wr_ptr + 1'b1;
            len_q  <= wr_ptr + 1'b1;
            if (ld_last)     state <= S_DONE;
            else if (at_end) state <= S_ERR;
`endif
          end
        end
        default: begin
          if (ld_start) begin
            state  <= S_LOAD;
            wr_ptr <= '0;
            len_q  <= '0;
`ifdef IMEM_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
      endcase
    end
  end

  // Memory contents survive reset; len_q masks anything stale.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= ld_data;
  end

  // 65-bit sum so that PCs near 2^64 cannot wrap into range.
  logic [64:0] win_end;
  assign win_end   = {1'b0, fetch_pc} + 65'd9;
  assign fetch_err = (win_end >= 65'(MEM_BYTES));

  // When fetch_err is low, fetch_pc <= MEM_BYTES-10, so the low ADDR_W+1 bits
  // hold the full address and lane addresses cannot overflow.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [ADDR_W:0] addr;
    assign addr = fetch_pc[ADDR_W:0] + (ADDR_W+1)'(k);
    assign fetch_instr[79-8*k -: 8] =
      (!fetch_err && (addr < len_q)) ? mem[addr[ADDR_W-1:0]] : 8'h00;
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int MEM = 1024;
`ifdef IMEM_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready;
  logic [63:0] fetch_pc = 64'd0;
  logic [79:0] fetch_instr;
  logic        fetch_err;
  logic [10:0] prog_len;
  logic        cpu_run, load_err;

  imem_loader #(.MEM_BYTES(MEM), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .prog_len(prog_len), .cpu_run(cpu_run), .load_err(load_err));

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 loading, 2 done, 3 error
  int         m_st;
  int         m_ptr, m_len;
  logic [7:0] m_xor;
  logic [7:0] m_mem [MEM];
  int         n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic m_reset();
    m_st = 0; m_ptr = 0; m_len = 0; m_xor = 8'h00;
  endtask

  // What the next clock edge does to the model for the given inputs.
  task automatic m_step(input logic st, input logic v, input logic last, input logic [7:0] d);
    if (m_st == 1) begin
      if (v) begin
        if (CK && last) begin
          m_st = (m_xor == d) ? 2 : 3;
        end else begin
          m_mem[m_ptr] = d;
          m_xor ^= d;
          m_ptr++;
          m_len = m_ptr;
          if (last)            m_st = 2;
          else if (m_ptr == MEM) m_st = 3;
        end
      end
    end else if (st) begin
      m_st = 1; m_ptr = 0; m_len = 0; m_xor = 8'h00;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".run"}, 80'(cpu_run), 80'(m_st == 2));
    chk({tag, ".err"}, 80'(load_err), 80'(m_st == 3));
    chk({tag, ".len"}, 80'(prog_len), 80'(m_len));
  endtask

  task automatic cyc(input logic st, input logic v, input logic last, input logic [7:0] d);
    @(negedge clk);
    ld_start = st; ld_valid = v; ld_last = last; ld_data = d;
    #1;
    chk("ready", 80'(ld_ready), 80'(m_st == 1));
    m_step(st, v, last, d);
    @(posedge clk);
    #1;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    chk_state("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst.ready", 80'(ld_ready), 80'(0));
    chk_state("rst");
  endtask

  function automatic logic [79:0] exp_fetch(input logic [63:0] pc);
    logic [79:0] r;
    r = '0;
    if (pc > 64'd1014) return r;
    for (int k = 0; k < 10; k++)
      if (int'(pc) + k < m_len) r[79-8*k -: 8] = m_mem[int'(pc) + k];
    return r;
  endfunction

  task automatic chk_fetch(input logic [63:0] pc);
    fetch_pc = pc;
    #1;
    chk($sformatf("instr@%0h", pc), fetch_instr, exp_fetch(pc));
    chk($sformatf("ferr@%0h", pc), 80'(fetch_err), 80'(pc > 64'd1014));
  endtask

  task automatic fetch_set();
    chk_fetch(64'd0); chk_fetch(64'd2); chk_fetch(64'd4);
    if (m_len >= 10) chk_fetch(64'(m_len - 10));
    if (m_len >= 5)  chk_fetch(64'(m_len - 5));
    chk_fetch(64'($urandom_range(0, 1014)));
    chk_fetch(64'd1013); chk_fetch(64'd1014);
    chk_fetch(64'h1_0000_0000); chk_fetch(64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  function automatic bq_t rand_q(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // gap: 0 none, 1 alternate idle cycles, 2 random idle cycles (with stray ld_start)
  task automatic load(input bq_t bq, input int gap, input bit with_last, input bit fix_ck);
    bq_t b;
    logic [7:0] x;
    b = bq;
    if (fix_ck && CK && with_last) begin
      x = 8'h00;
      for (int i = 0; i < b.size() - 1; i++) x ^= b[i];
      b[b.size()-1] = x;
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < b.size(); i++) begin
      if (gap == 1) cyc(1'b0, 1'b0, 1'b0, 8'($urandom));
      if (gap == 2)
        while ($urandom_range(0, 2) == 0)
          cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom), 8'($urandom));
      cyc(1'b0, 1'b1, with_last && (i == b.size() - 1), b[i]);
    end
    // bytes offered after the load must be dropped
    cyc(1'b0, 1'b1, 1'b0, 8'($urandom));
    cyc(1'b0, 1'b1, 1'b1, 8'($urandom));
    fetch_set();
  endtask

  initial begin
    bq_t q;
    m_reset();
    do_reset();
    do_reset();
    chk_fetch(64'd0);

    // directed 12-byte program
    q = '{8'h10, 8'h20, 8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h02};
    load(q, 0, 1'b1, 1'b0);
    for (int p = 0; p < 14; p++) chk_fetch(64'(p));

    // five bytes with valid toggling
    load(rand_q(5), 1, 1'b1, 1'b1);

    // overflow then exact fill
    load(rand_q(MEM), 0, 1'b0, 1'b0);
    load(rand_q(MEM), 0, 1'b1, 1'b1);
    for (int p = 1005; p < 1016; p++) chk_fetch(64'(p));

    // reset after 3 of 8 bytes, then a full load
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom));
    do_reset();
    chk_fetch(64'd0);
    chk_fetch(64'd1);
    load(rand_q(8), 0, 1'b1, 1'b1);

    // single-byte image: 00 then nonzero
    load('{8'h00}, 0, 1'b1, 1'b0);
    load('{8'h5A}, 0, 1'b1, 1'b0);

    // checksum pair: 10 20 + 30 (good) then 31 (bad)
    load('{8'h10, 8'h20, 8'h30}, 0, 1'b1, 1'b0);
    load('{8'h10, 8'h20, 8'h31}, 0, 1'b1, 1'b0);

    // randomized loads
    for (int t = 0; t < 20; t++)
      load(rand_q($urandom_range(1, 40)), 2, 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 2) != 0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
